// File: rtl/regmove_sequencer_if.sv
// ---------------------------------------------------------------------------
// regmove_sequencer_if
// Purpose : groups the move-request handshake and the register-bus control
//           signals of regmove_sequencer into one bundle.
// Modports: master - the requester (drives req*, observes everything else)
//           slave  - the sequencer (drives reqReady and all bus controls)
// Signals : reqValid/reqReady handshake, reqSrc (0=A 1=X 2=IMM 3=illegal),
//           reqDst {A,B,X,Q} mask, reqImm; assertBarA/assertBarX (active-low
//           drive enables), triggerA/B/X/Q load strobes, immOe/immOut,
//           done, err, busy status.
// ---------------------------------------------------------------------------
interface regmove_sequencer_if;
    logic       reqValid;
    logic       reqReady;
    logic [1:0] reqSrc;
    logic [3:0] reqDst;
    logic [7:0] reqImm;

    logic       assertBarA;
    logic       assertBarX;
    logic       triggerA;
    logic       triggerB;
    logic       triggerX;
    logic       triggerQ;
    logic       immOe;
    logic [7:0] immOut;
    logic       done;
    logic       err;
    logic       busy;

    modport master (
        output reqValid, reqSrc, reqDst, reqImm,
        input  reqReady, assertBarA, assertBarX,
        input  triggerA, triggerB, triggerX, triggerQ,
        input  immOe, immOut, done, err, busy
    );

    modport slave (
        input  reqValid, reqSrc, reqDst, reqImm,
        output reqReady, assertBarA, assertBarX,
        output triggerA, triggerB, triggerX, triggerQ,
        output immOe, immOut, done, err, busy
    );
endinterface

// File: rtl/regmove_sequencer.sv
// ---------------------------------------------------------------------------
// regmove_sequencer
// Purpose : sequences register-to-register moves over a shared 8-bit bus with
//           four registers {A,B,X,Q}. Each move walks SETUP (source drives the
//           bus), LATCH (destination load strobes for one cycle) and HOLD
//           (source still driven, done pulses). Illegal requests (source 3 or
//           empty destination mask) are swallowed and answered with err.
// Ports   : clkBar   - sole clock, state updates on its rising edge
//           resetBar - asynchronous active-low reset
//           bus      - regmove_sequencer_if.slave (request handshake, bus
//                      drive enables, load strobes, status pulses)
// Config  : define REGSEQ_QUEUE_EN to insert a 2-entry request FIFO between
//           the request port and the FSM; without it a request is accepted
//           only while IDLE.
// ---------------------------------------------------------------------------
module regmove_sequencer (
    input  logic                 clkBar,
    input  logic                 resetBar,
    regmove_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LATCH = 2'd2,
        HOLD  = 2'd3
    } stateT;

    typedef enum logic [1:0] {
        SRC_A   = 2'd0,
        SRC_X   = 2'd1,
        SRC_IMM = 2'd2,
        SRC_BAD = 2'd3
    } srcT;

    typedef struct packed {
        logic [1:0] src;
        logic [3:0] dst;
        logic [7:0] imm;
    } moveT;

    stateT state;
    stateT stateNext;
    moveT  cur;          // move currently being executed
    moveT  loadVal;      // move that enters SETUP on the next edge
    moveT  incoming;
    logic  loadCur;
    logic  readyEn;      // low in reset and until the first edge after release
    logic  errPulse;
    logic  accept;
    logic  illegal;
    logic  legalAccept;
    logic  driving;

    assign incoming    = {bus.reqSrc, bus.reqDst, bus.reqImm};
    assign illegal     = (bus.reqSrc == SRC_BAD) || (bus.reqDst == 4'b0000);
    assign accept      = bus.reqValid && bus.reqReady;
    assign legalAccept = accept && !illegal;

`ifdef REGSEQ_QUEUE_EN
    moveT       fifoMem [2];
    logic       wrPtr;
    logic       rdPtr;
    logic [1:0] fifoCount;
    logic       fifoPush;
    logic       fifoPop;

    // A full FIFO refuses a push even if HOLD pops on the same edge.
    assign bus.reqReady = readyEn && (fifoCount != 2'd2);
`else
    assign bus.reqReady = readyEn && (state == IDLE);
`endif

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        stateNext = state;
        loadCur   = 1'b0;
        loadVal   = incoming;
`ifdef REGSEQ_QUEUE_EN
        fifoPop   = 1'b0;
`endif
        case (state)
            // IDLE and HOLD share the "start the next move" decision: a
            // buffered request has priority, otherwise a request arriving
            // this cycle goes straight to SETUP so latency stays N+1.
            IDLE, HOLD: begin
                stateNext = IDLE;
`ifdef REGSEQ_QUEUE_EN
                if (fifoCount != 2'd0) begin
                    stateNext = SETUP;
                    loadCur   = 1'b1;
                    loadVal   = fifoMem[rdPtr];
                    fifoPop   = 1'b1;
                end else
`endif
                if (legalAccept) begin
                    stateNext = SETUP;
                    loadCur   = 1'b1;
                    loadVal   = incoming;
                end
            end
            SETUP:   stateNext = LATCH;
            LATCH:   stateNext = HOLD;
            default: stateNext = IDLE;
        endcase
    end

`ifdef REGSEQ_QUEUE_EN
    // A legal request is buffered unless it was taken directly into SETUP.
    assign fifoPush = legalAccept && !(loadCur && !fifoPop);
`endif

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clkBar or negedge resetBar) begin
        if (!resetBar) begin
            state    <= IDLE;
            readyEn  <= 1'b0;
            errPulse <= 1'b0;
            cur      <= '0;
        end else begin
            state    <= stateNext;
            readyEn  <= 1'b1;
            errPulse <= accept && illegal;
            if (loadCur) begin
                cur <= loadVal;
            end
        end
    end

`ifdef REGSEQ_QUEUE_EN
    always_ff @(posedge clkBar or negedge resetBar) begin
        if (!resetBar) begin
            wrPtr     <= 1'b0;
            rdPtr     <= 1'b0;
            fifoCount <= 2'd0;
        end else begin
            if (fifoPush) begin
                wrPtr <= ~wrPtr;
            end
            if (fifoPop) begin
                rdPtr <= ~rdPtr;
            end
            fifoCount <= fifoCount + {1'b0, fifoPush} - {1'b0, fifoPop};
        end
    end

    // NOTE: FIFO storage has no reset; entries are only read while
    // fifoCount says they were written, and reset clears the count.
    always_ff @(posedge clkBar) begin
        if (fifoPush) begin
            fifoMem[wrPtr] <= incoming;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Outputs: decoded from state so an asynchronous reset releases the bus
    // and the strobes immediately.
    // ---------------------------------------------------------------------
    assign driving = (state != IDLE);

    always_comb begin
        bus.assertBarA = !(driving && (cur.src == SRC_A));
        bus.assertBarX = !(driving && (cur.src == SRC_X));
        bus.immOe      = driving && (cur.src == SRC_IMM);
        bus.immOut     = bus.immOe ? cur.imm : 8'h00;
        {bus.triggerA, bus.triggerB, bus.triggerX, bus.triggerQ} =
            (state == LATCH) ? cur.dst : 4'b0000;
        bus.done       = (state == HOLD);
        bus.err        = errPulse;
`ifdef REGSEQ_QUEUE_EN
        bus.busy       = driving || (fifoCount != 2'd0);
`else
        bus.busy       = driving;
`endif
    end

endmodule
